// File: rtl/bram_tdp_1ck_be.sv
// True dual-port single-clock RAM with per-byte write enables, same-address
// collision merging, optional power-up clear and 1- or 2-cycle read pipeline.
module bram_tdp_1ck_be #(
  parameter int unsigned RAM_WIDTH      = 32,
  parameter int unsigned RAM_DEPTH      = 1024,
  parameter string       WRITE_MODE     = "WRITE_FIRST",
  parameter int unsigned READ_LATENCY   = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned NB = RAM_WIDTH / 8,
  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NB-1:0]        wea,
  input  logic [AW-1:0]        addra,
  input  logic [RAM_WIDTH-1:0] dina,
  output logic [RAM_WIDTH-1:0] douta,
  output logic                 vlda,
  input  logic                 enb,
  input  logic [NB-1:0]        web,
  input  logic [AW-1:0]        addrb,
  input  logic [RAM_WIDTH-1:0] dinb,
  output logic [RAM_WIDTH-1:0] doutb,
  output logic                 vldb,
  output logic                 rdy,
  output logic                 collision
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(RAM_DEPTH);
  localparam bit            MODE_WF   = (WRITE_MODE == "WRITE_FIRST");
  localparam bit            MODE_NC   = (WRITE_MODE == "NO_CHANGE");

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] clr_cnt;

  logic                 acc_a, acc_b, in_a, in_b, is_wr_a, is_wr_b, wr_a, wr_b;
  logic                 hit_coll, rsp_vld_a, rsp_vld_b;
  logic [RAM_WIDTH-1:0] old_a, old_b, post_a, post_b, rsp_a, rsp_b;

  logic                 s1_vld_a, s1_vld_b, s1_coll;
  logic [RAM_WIDTH-1:0] s1_dat_a, s1_dat_b;

  // Control FSM: next state
  always_comb begin
    state_nxt = state;
    if (rst) begin
      state_nxt = ST_RESET;
    end else begin
      case (state)
        ST_RESET: state_nxt = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        ST_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = ST_READY;
        ST_READY: state_nxt = ST_READY;
        default:  state_nxt = ST_RESET;
      endcase
    end
  end

  // Control FSM: state, ready flag and saturating clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RESET;
      rdy     <= 1'b0;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      rdy   <= (state_nxt == ST_READY);
      if (state != ST_CLEAR) begin
        clr_cnt <= '0;
      end else if (clr_cnt != LAST_ADDR) begin
        clr_cnt <= clr_cnt + AW'(1);
      end
    end
  end

  assign acc_a    = ena & rdy & ~rst;
  assign acc_b    = enb & rdy & ~rst;
  assign in_a     = ({1'b0, addra} < DEPTH_EXT);
  assign in_b     = ({1'b0, addrb} < DEPTH_EXT);
  assign is_wr_a  = |wea;
  assign is_wr_b  = |web;
  assign wr_a     = acc_a & in_a & is_wr_a;
  assign wr_b     = acc_b & in_b & is_wr_b;
  assign hit_coll = acc_a & acc_b & (addra == addrb) & (is_wr_a | is_wr_b);

  assign old_a = in_a ? mem[addra] : '0;
  assign old_b = in_b ? mem[addrb] : '0;

  // Post-write word seen at each address; port A bytes win on overlap
  always_comb begin
    post_a = old_a;
    post_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_b && web[i] && (addrb == addra)) post_a[8*i +: 8] = dinb[8*i +: 8];
      if (wr_a && wea[i])                     post_a[8*i +: 8] = dina[8*i +: 8];
      if (wr_b && web[i])                     post_b[8*i +: 8] = dinb[8*i +: 8];
      if (wr_a && wea[i] && (addra == addrb)) post_b[8*i +: 8] = dina[8*i +: 8];
    end
  end

  // Reads always see the pre-write word; writes answer by mode
  assign rsp_a     = (is_wr_a && MODE_WF) ? post_a : old_a;
  assign rsp_b     = (is_wr_b && MODE_WF) ? post_b : old_b;
  assign rsp_vld_a = acc_a & ~(is_wr_a & MODE_NC);
  assign rsp_vld_b = acc_b & ~(is_wr_b & MODE_NC);

  // Array update: clear sweep, else byte writes with port A applied last
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR && !rst) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
        if (wr_a && wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  // Stage 1: data registers hold when no response is produced
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_a <= 1'b0;
      s1_vld_b <= 1'b0;
      s1_coll  <= 1'b0;
      s1_dat_a <= '0;
      s1_dat_b <= '0;
    end else begin
      s1_vld_a <= rsp_vld_a;
      s1_vld_b <= rsp_vld_b;
      s1_coll  <= hit_coll;
      if (rsp_vld_a) s1_dat_a <= rsp_a;
      if (rsp_vld_b) s1_dat_b <= rsp_b;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                 s2_vld_a, s2_vld_b, s2_coll;
      logic [RAM_WIDTH-1:0] s2_dat_a, s2_dat_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_vld_a <= 1'b0;
          s2_vld_b <= 1'b0;
          s2_coll  <= 1'b0;
          s2_dat_a <= '0;
          s2_dat_b <= '0;
        end else begin
          s2_vld_a <= s1_vld_a;
          s2_vld_b <= s1_vld_b;
          s2_coll  <= s1_coll;
          if (s1_vld_a) s2_dat_a <= s1_dat_a;
          if (s1_vld_b) s2_dat_b <= s1_dat_b;
        end
      end

      assign douta     = s2_dat_a;
      assign doutb     = s2_dat_b;
      assign vlda      = s2_vld_a;
      assign vldb      = s2_vld_b;
      assign collision = s2_coll;
    end else begin : g_lat1
      assign douta     = s1_dat_a;
      assign doutb     = s1_dat_b;
      assign vlda      = s1_vld_a;
      assign vldb      = s1_vld_b;
      assign collision = s1_coll;
    end
  endgenerate

endmodule

// File: tb/tb_bram_tdp_1ck_be.sv
// Bench for bram_tdp_1ck_be: three instances (WRITE_FIRST/L2, READ_FIRST/L1,
// NO_CHANGE/L2) share stimulus and are checked every cycle against a word-level model.
module tb_bram_tdp_1ck_be;

  localparam int W    = 32;
  localparam int D    = 16;
  localparam int AW   = 4;
  localparam int NB   = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ena, enb;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [W-1:0]  dina, dinb;

  logic [W-1:0] dout [3][2];
  logic         vld  [3][2];
  logic         rdy  [3];
  logic         coll [3];

  bram_tdp_1ck_be #(.RAM_WIDTH(W), .RAM_DEPTH(D), .WRITE_MODE("WRITE_FIRST"),
                    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[0][0]), .vlda(vld[0][0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[0][1]), .vldb(vld[0][1]),
    .rdy(rdy[0]), .collision(coll[0]));

  bram_tdp_1ck_be #(.RAM_WIDTH(W), .RAM_DEPTH(D), .WRITE_MODE("READ_FIRST"),
                    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[1][0]), .vlda(vld[1][0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[1][1]), .vldb(vld[1][1]),
    .rdy(rdy[1]), .collision(coll[1]));

  bram_tdp_1ck_be #(.RAM_WIDTH(W), .RAM_DEPTH(D), .WRITE_MODE("NO_CHANGE"),
                    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u2 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[2][0]), .vlda(vld[2][0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[2][1]), .vldb(vld[2][1]),
    .rdy(rdy[2]), .collision(coll[2]));

  // Word-level model: memory image, ready timing and scheduled responses
  logic [W-1:0] m [D];
  bit           sv [3][2][MAXC];
  logic [W-1:0] sd [3][2][MAXC];
  bit           sc [3][MAXC];
  logic [W-1:0] last [3][2];
  int           since_rel = 0;
  bit           mrdy = 1'b0;
  bit           rst_edge = 1'b0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  function automatic int lat(int k);
    return (k == 1) ? 1 : 2;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_rdy", k), W'(rdy[k]), W'(mrdy));
      for (int p = 0; p < 2; p++) begin
        bit ev;
        ev = !rst_edge && sv[k][p][cyc];
        if (rst_edge) last[k][p] = '0;
        else if (ev)  last[k][p] = sd[k][p][cyc];
        chk($sformatf("u%0d_vld%s", k, (p == 0) ? "a" : "b"), W'(vld[k][p]), W'(ev));
        chk($sformatf("u%0d_dout%s", k, (p == 0) ? "a" : "b"), dout[k][p], last[k][p]);
      end
      chk($sformatf("u%0d_collision", k), W'(coll[k]), W'(!rst_edge && sc[k][cyc]));
    end
  endtask

  // Advance one clock: model the edge, then check all outputs at the falling edge
  task automatic step();
    int n;
    bit acc_a, acc_b, wa, wb, col;
    logic [W-1:0] oa, ob;
    n     = cyc + 1;
    acc_a = ena && mrdy && !rst;
    acc_b = enb && mrdy && !rst;
    wa    = acc_a && (wea != '0);
    wb    = acc_b && (web != '0);
    col   = acc_a && acc_b && (addra == addrb) && (wa || wb);
    oa    = m[addra];
    ob    = m[addrb];
    for (int i = 0; i < NB; i++) if (wb && web[i]) m[addrb][8*i +: 8] = dinb[8*i +: 8];
    for (int i = 0; i < NB; i++) if (wa && wea[i]) m[addra][8*i +: 8] = dina[8*i +: 8];
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = n + lat(k) - 1;
      if (acc_a && !(wa && k == 2)) begin
        sv[k][0][idx] = 1'b1;
        sd[k][0][idx] = (wa && k == 0) ? m[addra] : oa;
      end
      if (acc_b && !(wb && k == 2)) begin
        sv[k][1][idx] = 1'b1;
        sd[k][1][idx] = (wb && k == 0) ? m[addrb] : ob;
      end
      if (col) sc[k][idx] = 1'b1;
    end
    if (rst) begin
      since_rel = 0;
      mrdy      = 1'b0;
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          sv[k][p][n]   = 1'b0;
          sv[k][p][n+1] = 1'b0;
        end
        sc[k][n]   = 1'b0;
        sc[k][n+1] = 1'b0;
      end
    end else begin
      since_rel++;
      if (since_rel == D + 1) for (int j = 0; j < D; j++) m[j] = '0;
      mrdy = (since_rel >= D + 1);
    end
    rst_edge = rst;
    @(posedge clk);
    cyc = n;
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  initial begin
    int cnt;
    for (int j = 0; j < D; j++) m[j] = '0;
    for (int k = 0; k < 3; k++) begin
      last[k][0] = '0;
      last[k][1] = '0;
    end
    rst = 1'b1; idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    repeat (3) step();

    // Release with ena held: ready after 17 edges, then read addr 5
    ena = 1'b1; addra = 4'd5; rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("rdy_rise", W'(rdy[0]), W'(i == 17));
    end
    step();
    chk("lat1_vld", W'(vld[1][0]), 32'd1);
    chk("lat1_dout", dout[1][0], 32'h0);
    chk("lat2_not_yet", W'(vld[0][0]), 32'd0);
    step();
    chk("lat2_vld", W'(vld[0][0]), 32'd1);
    chk("lat2_dout", dout[0][0], 32'h0);
    idle();

    // Byte-enable merge
    ena = 1'b1; wea = 4'hF; addra = 4'd3; dina = 32'hAABBCCDD; step();
    wea = 4'b0101; dina = 32'h11223344; step();
    idle(); enb = 1'b1; addrb = 4'd3; step();
    idle(); step();
    chk("be_merge", dout[0][1], 32'hAA22CC44);

    // Write-mode response
    ena = 1'b1; wea = 4'hF; addra = 4'd7; dina = 32'h1; step();
    dina = 32'h2; step();
    chk("rf_dout", dout[1][0], 32'h1);
    chk("rf_vld", W'(vld[1][0]), 32'd1);
    idle(); step();
    chk("wf_dout", dout[0][0], 32'h2);
    chk("nc_vld", W'(vld[2][0]), 32'd0);
    chk("nc_hold", dout[2][0], 32'h0);

    // Both ports write the same address
    ena = 1'b1; wea = 4'b1100; addra = 4'd9; dina = 32'hFFFF0000;
    enb = 1'b1; web = 4'hF;    addrb = 4'd9; dinb = 32'h0000FFFF; step();
    chk("coll_l1", W'(coll[1]), 32'd1);
    idle(); step();
    chk("coll_l2", W'(coll[0]), 32'd1);
    chk("coll_nc", W'(coll[2]), 32'd1);
    chk("coll_nc_novld", W'(vld[2][1]), 32'd0);
    ena = 1'b1; addra = 4'd9; step();
    idle(); step();
    chk("coll_merge", dout[0][0], 32'hFFFFFFFF);

    // Write A / read B same address
    ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'h9; step();
    dina = 32'h5; enb = 1'b1; web = '0; addrb = 4'd2; step();
    idle(); step();
    chk("wr_rd_old", dout[0][1], 32'h9);
    chk("wr_rd_coll", W'(coll[0]), 32'd1);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 1500; i++) begin
      ena = 1'($urandom_range(0, 1));
      enb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) != 0) begin
        addra = AW'($urandom_range(0, 2));
        addrb = AW'($urandom_range(0, 2));
      end else begin
        addra = AW'($urandom_range(0, D - 1));
        addrb = AW'($urandom_range(0, D - 1));
      end
      wea  = ($urandom_range(0, 1) != 0) ? '0 : NB'($urandom);
      web  = ($urandom_range(0, 1) != 0) ? '0 : NB'($urandom);
      dina = $urandom;
      dinb = $urandom;
      rst  = (i >= 700 && i < 702);
      step();
    end
    rst = 1'b0;

    // Reset at clear address 8 restarts the sweep
    idle(); step(); step();
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (9) step();
    rst = 1'b1; step();
    rst = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      step();
      cnt++;
      if (rdy[0] === 1'b1) break;
    end
    chk("rdy_restart", W'(cnt), 32'd17);
    ena = 1'b1; addra = 4'd3; step();
    idle(); step();
    chk("cleared_word", dout[0][0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
